// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - 32x64 register file, two combinational read ports, one write port, register 31 reads zero.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // Only indices 0..NUM_REGS-2 have storage; the zero register is the last index.
  logic [WIDTH-1:0]    regs   [NUM_REGS-1];
  logic [NUM_REGS-2:0] we;
  logic [WIDTH-1:0]    mux_in [NUM_REGS];

  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      we[i] = RegWrite && (WriteRegister == 5'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= we[i] ? WriteData : regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_mux_in
    if (g == ZERO_REG) begin : g_zero
      assign mux_in[g] = '0;
    end else begin : g_reg
      assign mux_in[g] = regs[g];
    end
  end

  // Four 8:1 groups on addr[2:0], then a 4:1 on addr[4:3].
  function automatic logic [WIDTH-1:0] mux_tree(input logic [4:0] addr);
    logic [WIDTH-1:0] grp [4];
    for (int g = 0; g < 4; g++) begin
      grp[g] = mux_in[{g[1:0], addr[2:0]}];
    end
    return grp[addr[4:3]];
  endfunction

`ifdef REGFILE_BYPASS_EN
  function automatic logic fwd(input logic [4:0] addr);
    return !reset && RegWrite && (WriteRegister == addr) &&
           (WriteRegister != 5'(ZERO_REG));
  endfunction

  always_comb begin
    ReadData1 = fwd(ReadRegister1) ? WriteData : mux_tree(ReadRegister1);
    ReadData2 = fwd(ReadRegister2) ? WriteData : mux_tree(ReadRegister2);
  end
`else
  always_comb begin
    ReadData1 = mux_tree(ReadRegister1);
    ReadData2 = mux_tree(ReadRegister2);
  end
`endif

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry x 64-bit register file for the pipelined processor.
- Sits between the decode stage (register addresses) and the execute stage (operand inputs).
- Two combinational read ports are built from the team's 2:1/4:1/8:1 mux tree, giving a 32:1 mux per data bit.
- One synchronous write port, driven by writeback; register 31 reads as zero.

Parameters:
- WIDTH, 64, data width of each register and each data port.
- NUM_REGS, 32, number of registers. Fixed at 32; the address width is 5 bits.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register to 0.
- RegWrite  input  1  write enable from writeback.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  value to write.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  WIDTH  contents of ReadRegister1.
- ReadData2  output  WIDTH  contents of ReadRegister2.

Behaviour:
- Storage: 31 physical 64-bit registers (indices 0..30), each made of D flip-flops with asynchronous reset. Index 31 has no storage.
- Reset: when reset=1, all registers go to 0 immediately, independent of clk. ReadData1 and ReadData2 are therefore 0 during reset for any address.
- Reset released mid-cycle: no write occurs until the next rising edge with reset=0.
- Write decode: a 5:32 decoder gated by RegWrite produces a one-hot enable.
  - Register i loads WriteData on a rising clk edge iff RegWrite=1, WriteRegister=i and reset=0.
  - Otherwise register i holds its value; each bit is recirculated through a 2:1 mux selected by its enable.
- Writes to register 31 are discarded: no state change, and the port accepts them silently.
- RegWrite=0: no register changes, whatever WriteRegister and WriteData are.
- Read ports:
  - Purely combinational, with zero-cycle latency from address to data.
  - Per bit: four 8:1 muxes select on address[2:0]; a 4:1 mux selects on address[4:3].
  - The input for index 31 is tied to 0, so reading register 31 always returns 64'h0.
- Both ports may read the same register simultaneously, with identical results.
- Write/read same cycle, same register (base behaviour):
  - The read returns the old value until the rising edge.
  - It returns the new value after that edge.
- Write latency: data written at edge N is visible on the read ports immediately after edge N.
- No X propagation: every output bit is driven for all 32 addresses.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: internal write-to-read forwarding is added.
  - Condition: RegWrite=1, WriteRegister == ReadRegisterK, and WriteRegister != 31.
  - Result: ReadDataK equals WriteData combinationally in the same cycle, before the edge.
  - Forwarding never applies to register 31, which still reads 0.
  - Forwarding is suppressed while reset=1; outputs are 0.
- Not defined: no forwarding; the same-cycle read returns the pre-edge stored value, as in Behaviour.
- Either way, stored state after the edge is identical.

Test Plan:
- Reset: preload X5=64'hDEADBEEF_CAFEF00D, assert reset asynchronously mid-cycle.
  - ReadData1 (addr 5) goes to 0 before the next clk edge.
  - All 31 registers read 0 after reset.
- Write/readback sweep: for i=0..30 write WriteData=i*64'h0101010101010101 with RegWrite=1, one per cycle.
  - Then read all pairs (i, 30-i).
  - Both ports return their written values, with no aliasing between indices.
- Zero register: write WriteRegister=31, WriteData=64'hFFFFFFFF_FFFFFFFF.
  - ReadData1 and ReadData2 (both addr 31) stay 64'h0 before and after the edge, with and without REGFILE_BYPASS_EN.
- Write enable low: X7=64'h1234, then RegWrite=0, WriteRegister=7, WriteData=64'h9999 over 3 edges.
  - X7 still reads 64'h1234.
- Same-cycle hazard: X3=64'hAAAA; in one cycle drive RegWrite=1, WriteRegister=3, WriteData=64'hBBBB, ReadRegister2=3.
  - Before the edge, ReadData2 = 64'hAAAA without the macro and 64'hBBBB with REGFILE_BYPASS_EN.
  - After the edge, ReadData2 = 64'hBBBB in both builds.
- Dual-port conflict: ReadRegister1=ReadRegister2=12 with X12=64'h0F0F.
  - Both outputs are 64'h0F0F.
  - A simultaneous write to X13 does not disturb either output.
